seg_monitor: RTL and testbench
==============================

// Module: seg_monitor
// PURPOSE
//  Receive-side checker for the two-digit seven-segment counter display.
//  Samples seg_1/seg_10 on a strobe and decodes each pattern back to BCD.
//  Checks that consecutive readings form a legal count sequence (hold, +1, wrap, restart).
//  Reports the decoded value, lock status, error pulses and a saturating error count.
//  Sits beside the display driver in self-check builds and in board bring-up.
// PARAMETERS
//  WRAP_VAL  99   last legal count (decimal, 1..99); the step after WRAP_VAL is 00
//  HOLD_MAX  16   consecutive identical samples before stall is raised (>=2)
// PORTS
//  CLK      in   1  system clock, all logic on rising edge
//  RST      in   1  synchronous reset, active-high
//  SMP      in   1  sample strobe; seg inputs are ignored when low
//  seg_1    in   7  ones-digit pattern, bit6=a ... bit0=g, active-high
//  seg_10   in   7  tens-digit pattern, same encoding
//  bcd_0    out  4  last decoded ones digit
//  bcd_1    out  4  last decoded tens digit
//  dv       out  1  one-cycle pulse: a new sample has been decoded
//  locked   out  1  tracking a valid sequence
//  err      out  1  one-cycle pulse: illegal pattern or illegal step
//  err_cnt  out  8  error count, saturates at 255
//  stall    out  1  value unchanged for >= HOLD_MAX samples
// BEHAVIOUR
//  Reset: bcd_0=bcd_1=0, dv=0, locked=0, err=0, err_cnt=0, stall=0, FSM=UNLOCKED, hold count=0.
//  RST wins over SMP in the same cycle.
//  Patterns 0-9: 7E,30,6D,79,33,5B,5F,70,7F,7B (hex). Every other pattern is illegal, including 00 (blank).
//  A legal digit also counts as illegal if its value is >9 or the pair exceeds WRAP_VAL.
//  Latency: SMP high at edge n -> dv, err, bcd_*, locked and stall are updated at edge n+1; dv and err are high for exactly one cycle.
//  No SMP -> dv=err=0; all other outputs hold.
//  Let V = the decoded pair and P = the previously stored value.
//  UNLOCKED, sample legal   -> store V, locked=1, go to LOCKED, no err.
//  UNLOCKED, sample illegal -> err, err_cnt++, stay UNLOCKED; bcd_* hold.
//  LOCKED, V==P             -> hold count++; stall=1 once the count reaches HOLD_MAX.
//  LOCKED, V==P+1, or P==WRAP_VAL and V==00 -> legal step; store V; clear hold count and stall.
//  LOCKED, V==00, any P     -> legal restart (counter reset); store V; clear hold count and stall.
//  LOCKED, any other legal V -> err, err_cnt++; store V (resync); stay LOCKED; clear hold count and stall.
//  LOCKED, illegal pattern   -> err, err_cnt++; go to UNLOCKED; locked=0; clear hold count and stall; bcd_* hold.
//  The hold count saturates at HOLD_MAX.
//  err_cnt stays at 255 once there; err still pulses.
//  BCD arithmetic: +1 carries from ones to tens at 9; compare as two BCD digits, not binary.
// TESTING
//  T1 reset, SMP with 00,01,..,WRAP_VAL,00 -> dv each sample, locked=1 after first, err never, err_cnt=0.
//  T2 locked at 37, SMP with 39 -> err pulse one cycle after SMP, err_cnt=1, bcd=39, still locked.
//  T3 locked at 12, seg_1=7'h00 (blank) -> err, locked=0, bcd holds 12; next legal 45 -> locked=1, no err.
//  T4 locked at 05, 16 identical SMPs (HOLD_MAX=16) -> stall=1 at the 16th; then 06 -> stall=0, no err.
//  T5 locked at 58, SMP with 00 -> restart accepted, no err; WRAP_VAL=59: 59 then 00 -> no err.
//  T6 300 illegal samples -> err_cnt=255 saturated; RST asserted together with SMP -> all outputs 0 next cycle.

Source files
------------

// File: rtl/seg_monitor_if.sv
// Signal bundle between a seven-segment display source and the seg_monitor checker.
// The master side drives the strobe and segment patterns. The slave side (the
// monitor) returns the decoded value and the status flags.
interface seg_monitor_if;
    logic       SMP;
    logic [6:0] seg_1;
    logic [6:0] seg_10;
    logic [3:0] bcd_0;
    logic [3:0] bcd_1;
    logic       dv;
    logic       locked;
    logic       err;
    logic [7:0] err_cnt;
    logic       stall;

    modport master (
        output SMP, seg_1, seg_10,
        input  bcd_0, bcd_1, dv, locked, err, err_cnt, stall
    );

    modport slave (
        input  SMP, seg_1, seg_10,
        output bcd_0, bcd_1, dv, locked, err, err_cnt, stall
    );
endinterface

// File: rtl/seg_monitor.sv
// Receive-side checker for a two-digit seven-segment counter display.
// On each strobe it decodes both digits back to BCD and checks that the new
// reading follows the previous one in a legal way: hold, +1, wrap or restart.
//
// state    | meaning
// ---------+----------------------------------------------------------
// UNLOCKED | no trusted reference value; waiting for a legal pattern
// LOCKED   | tracking the sequence against the stored value P
module seg_monitor #(
    parameter int WRAP_VAL = 99,
    parameter int HOLD_MAX = 16
) (
    input  logic         CLK,
    input  logic         RST,
    seg_monitor_if.slave bus
);

    localparam int         HW       = $clog2(HOLD_MAX + 1);
    localparam logic [3:0] WRAP_T   = 4'(WRAP_VAL / 10);
    localparam logic [3:0] WRAP_O   = 4'(WRAP_VAL % 10);
    localparam logic [HW-1:0] HOLD_SAT = HW'(HOLD_MAX);

    typedef enum logic {S_UNLOCKED = 1'b0, S_LOCKED = 1'b1} state_t;

    state_t          r_state, w_state_nxt;
    logic [3:0]      r_bcd0, r_bcd1, w_bcd0_nxt, w_bcd1_nxt;
    logic            r_dv, w_dv_nxt;
    logic            r_err, w_err_nxt;
    logic [7:0]      r_err_cnt, w_err_cnt_nxt;
    logic [HW-1:0]   r_hold, w_hold_nxt;
    logic            r_stall, w_stall_nxt;

    logic [4:0]      w_dec1, w_dec10;
    logic [7:0]      w_v, w_p, w_p_inc;
    logic            w_legal, w_same, w_step, w_zero;
    logic [7:0]      w_err_cnt_inc;
    logic [HW-1:0]   w_hold_inc;

    // Pattern to {valid, digit}; bit6 = segment a ... bit0 = segment g.
    // Only the ten digit patterns decode, so a decoded digit is always 0..9.
    function automatic logic [4:0] f_decode(input logic [6:0] seg);
        case (seg)
            7'h7E:   f_decode = {1'b1, 4'd0};
            7'h30:   f_decode = {1'b1, 4'd1};
            7'h6D:   f_decode = {1'b1, 4'd2};
            7'h79:   f_decode = {1'b1, 4'd3};
            7'h33:   f_decode = {1'b1, 4'd4};
            7'h5B:   f_decode = {1'b1, 4'd5};
            7'h5F:   f_decode = {1'b1, 4'd6};
            7'h70:   f_decode = {1'b1, 4'd7};
            7'h7F:   f_decode = {1'b1, 4'd8};
            7'h7B:   f_decode = {1'b1, 4'd9};
            default: f_decode = 5'b0_0000;
        endcase
    endfunction

    // Decode the current sample and compare it with the stored value as two BCD digits.
    always_comb begin
        w_dec1  = f_decode(bus.seg_1);
        w_dec10 = f_decode(bus.seg_10);
        w_v     = {w_dec10[3:0], w_dec1[3:0]};
        w_p     = {r_bcd1, r_bcd0};
        // Packed BCD keeps numeric order, so a plain compare against the BCD wrap value works.
        w_legal = w_dec1[4] & w_dec10[4] & (w_v <= {WRAP_T, WRAP_O});
        w_p_inc = (r_bcd0 == 4'd9) ? {r_bcd1 + 4'd1, 4'd0} : {r_bcd1, r_bcd0 + 4'd1};
        w_same  = (w_v == w_p);
        w_zero  = (w_v == 8'h00);
        w_step  = (w_v == w_p_inc) | ((w_p == {WRAP_T, WRAP_O}) & w_zero);
        w_err_cnt_inc = (r_err_cnt == 8'hFF) ? r_err_cnt : r_err_cnt + 8'd1;
        w_hold_inc    = (r_hold == HOLD_SAT) ? r_hold : r_hold + 1'b1;
    end

    // Next-state and next-output decision for one sample.
    always_comb begin
        w_state_nxt   = r_state;
        w_bcd0_nxt    = r_bcd0;
        w_bcd1_nxt    = r_bcd1;
        w_dv_nxt      = 1'b0;
        w_err_nxt     = 1'b0;
        w_err_cnt_nxt = r_err_cnt;
        w_hold_nxt    = r_hold;
        w_stall_nxt   = r_stall;
        if (bus.SMP) begin
            w_dv_nxt = 1'b1;
            case (r_state)
                S_UNLOCKED: begin
                    if (w_legal) begin
                        w_state_nxt = S_LOCKED;
                        w_bcd1_nxt  = w_v[7:4];
                        w_bcd0_nxt  = w_v[3:0];
                        w_hold_nxt  = '0;
                        w_stall_nxt = 1'b0;
                    end else begin
                        w_err_nxt     = 1'b1;
                        w_err_cnt_nxt = w_err_cnt_inc;
                    end
                end
                S_LOCKED: begin
                    if (!w_legal) begin
                        // Displayed value stays at the last good reading.
                        w_state_nxt   = S_UNLOCKED;
                        w_err_nxt     = 1'b1;
                        w_err_cnt_nxt = w_err_cnt_inc;
                        w_hold_nxt    = '0;
                        w_stall_nxt   = 1'b0;
                    end else if (w_same) begin
                        w_hold_nxt  = w_hold_inc;
                        w_stall_nxt = (w_hold_inc == HOLD_SAT);
                    end else begin
                        // Any other legal value is taken as the new reference (resync).
                        w_bcd1_nxt  = w_v[7:4];
                        w_bcd0_nxt  = w_v[3:0];
                        w_hold_nxt  = '0;
                        w_stall_nxt = 1'b0;
                        if (!(w_step || w_zero)) begin
                            w_err_nxt     = 1'b1;
                            w_err_cnt_nxt = w_err_cnt_inc;
                        end
                    end
                end
                default: w_state_nxt = S_UNLOCKED;
            endcase
        end
    end

    // State and output registers; reset has priority over a strobe in the same cycle.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state   <= S_UNLOCKED;
            r_bcd0    <= 4'd0;
            r_bcd1    <= 4'd0;
            r_dv      <= 1'b0;
            r_err     <= 1'b0;
            r_err_cnt <= 8'd0;
            r_hold    <= '0;
            r_stall   <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_bcd0    <= w_bcd0_nxt;
            r_bcd1    <= w_bcd1_nxt;
            r_dv      <= w_dv_nxt;
            r_err     <= w_err_nxt;
            r_err_cnt <= w_err_cnt_nxt;
            r_hold    <= w_hold_nxt;
            r_stall   <= w_stall_nxt;
        end
    end

    assign bus.bcd_0   = r_bcd0;
    assign bus.bcd_1   = r_bcd1;
    assign bus.dv      = r_dv;
    assign bus.locked  = (r_state == S_LOCKED);
    assign bus.err     = r_err;
    assign bus.err_cnt = r_err_cnt;
    assign bus.stall   = r_stall;

endmodule

// File: tb/tb_seg_monitor.sv
// Directed bench for seg_monitor. Two instances receive the same stimulus:
// dut_a uses the default WRAP_VAL=99 and dut_b uses WRAP_VAL=59.
module tb_seg_monitor;

    logic CLK = 1'b0;
    logic RST = 1'b1;
    int   n_checks = 0;
    int   n_fail   = 0;

    logic [6:0] SEG [10] = '{7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33,
                             7'h5B, 7'h5F, 7'h70, 7'h7F, 7'h7B};

    seg_monitor_if if_a ();
    seg_monitor_if if_b ();

    seg_monitor #(.WRAP_VAL(99), .HOLD_MAX(16)) dut_a (.CLK(CLK), .RST(RST), .bus(if_a));
    seg_monitor #(.WRAP_VAL(59), .HOLD_MAX(16)) dut_b (.CLK(CLK), .RST(RST), .bus(if_b));

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Present one strobed sample on both instances for exactly one edge.
    // On return the sample has been registered and SMP is low again.
    task automatic drive(input logic [6:0] t7, input logic [6:0] o7);
        @(negedge CLK);
        if_a.SMP = 1'b1; if_a.seg_10 = t7; if_a.seg_1 = o7;
        if_b.SMP = 1'b1; if_b.seg_10 = t7; if_b.seg_1 = o7;
        @(negedge CLK);
        if_a.SMP = 1'b0;
        if_b.SMP = 1'b0;
    endtask

    task automatic send(input int tens, input int ones);
        drive(SEG[tens], SEG[ones]);
    endtask

    task automatic do_reset();
        @(negedge CLK);
        RST = 1'b1; if_a.SMP = 1'b0; if_b.SMP = 1'b0;
        @(negedge CLK);
        @(negedge CLK);
        RST = 1'b0;
    endtask

    initial begin
        if_a.SMP = 1'b0; if_a.seg_1 = 7'h00; if_a.seg_10 = 7'h00;
        if_b.SMP = 1'b0; if_b.seg_1 = 7'h00; if_b.seg_10 = 7'h00;
        do_reset();

        // Reset state
        chk("rst_bcd",    {if_a.bcd_1, if_a.bcd_0}, 8'h00);
        chk("rst_dv",     if_a.dv, 1'b0);
        chk("rst_locked", if_a.locked, 1'b0);
        chk("rst_err",    if_a.err, 1'b0);
        chk("rst_errcnt", if_a.err_cnt, 8'd0);
        chk("rst_stall",  if_a.stall, 1'b0);

        // T1: full count 00..99 then wrap to 00
        for (int v = 0; v <= 100; v++) begin
            int w;
            w = v % 100;
            send(w / 10, w % 10);
            chk("t1_dv",     if_a.dv, 1'b1);
            chk("t1_err",    if_a.err, 1'b0);
            chk("t1_locked", if_a.locked, 1'b1);
            chk("t1_bcd",    {if_a.bcd_1, if_a.bcd_0}, {4'(w / 10), 4'(w % 10)});
        end
        @(negedge CLK);
        chk("t1_dv_drop", if_a.dv, 1'b0);
        chk("t1_errcnt",  if_a.err_cnt, 8'd0);
        chk("t1_hold",    {if_a.bcd_1, if_a.bcd_0}, 8'h00);

        // T2: illegal jump 37 -> 39 resyncs and stays locked
        do_reset();
        send(3, 7);
        chk("t2_lock", if_a.locked, 1'b1);
        send(3, 9);
        chk("t2_err",    if_a.err, 1'b1);
        chk("t2_errcnt", if_a.err_cnt, 8'd1);
        chk("t2_bcd",    {if_a.bcd_1, if_a.bcd_0}, 8'h39);
        chk("t2_locked", if_a.locked, 1'b1);
        @(negedge CLK);
        chk("t2_err_drop", if_a.err, 1'b0);
        chk("t2_errcnt_hold", if_a.err_cnt, 8'd1);
        send(4, 0);
        chk("t2_carry_err", if_a.err, 1'b0);
        chk("t2_carry_bcd", {if_a.bcd_1, if_a.bcd_0}, 8'h40);

        // T3: blank ones digit drops lock, bcd holds; legal value relocks
        do_reset();
        send(1, 2);
        drive(SEG[1], 7'h00);
        chk("t3_err",    if_a.err, 1'b1);
        chk("t3_locked", if_a.locked, 1'b0);
        chk("t3_bcd",    {if_a.bcd_1, if_a.bcd_0}, 8'h12);
        chk("t3_errcnt", if_a.err_cnt, 8'd1);
        send(4, 5);
        chk("t3_relock", if_a.locked, 1'b1);
        chk("t3_noerr",  if_a.err, 1'b0);
        chk("t3_bcd2",   {if_a.bcd_1, if_a.bcd_0}, 8'h45);

        // T4: stall after 16 repeats, cleared by the next step
        do_reset();
        send(0, 5);
        for (int i = 1; i <= 17; i++) begin
            send(0, 5);
            chk("t4_stall", if_a.stall, (i >= 16) ? 1'b1 : 1'b0);
            chk("t4_err",   if_a.err, 1'b0);
        end
        send(0, 6);
        chk("t4_unstall", if_a.stall, 1'b0);
        chk("t4_err6",    if_a.err, 1'b0);
        chk("t4_bcd6",    {if_a.bcd_1, if_a.bcd_0}, 8'h06);

        // T5: restart from 58, and wrap at 59 on the WRAP_VAL=59 instance
        do_reset();
        send(5, 8);
        send(0, 0);
        chk("t5_restart_err", if_a.err, 1'b0);
        chk("t5_restart_bcd", {if_a.bcd_1, if_a.bcd_0}, 8'h00);
        chk("t5_restart_lk",  if_a.locked, 1'b1);
        do_reset();
        send(5, 9);
        chk("t5_b_lock", if_b.locked, 1'b1);
        send(0, 0);
        chk("t5_b_wrap_err", if_b.err, 1'b0);
        chk("t5_b_wrap_lk",  if_b.locked, 1'b1);
        send(6, 0);
        chk("t5_b_over_err",    if_b.err, 1'b1);
        chk("t5_b_over_lk",     if_b.locked, 1'b0);
        chk("t5_b_over_bcd",    {if_b.bcd_1, if_b.bcd_0}, 8'h00);
        chk("t5_a_60_err",      if_a.err, 1'b1);

        // T6: error counter saturation, then reset beats a simultaneous strobe
        do_reset();
        for (int i = 1; i <= 300; i++) begin
            drive(7'h00, 7'h00);
            if (i == 254) chk("t6_cnt254", if_a.err_cnt, 8'd254);
        end
        chk("t6_sat",     if_a.err_cnt, 8'd255);
        chk("t6_err_sat", if_a.err, 1'b1);
        send(4, 2);
        chk("t6_lock42",  if_a.locked, 1'b1);
        @(negedge CLK);
        RST = 1'b1;
        if_a.SMP = 1'b1; if_a.seg_10 = SEG[4]; if_a.seg_1 = SEG[3];
        if_b.SMP = 1'b1; if_b.seg_10 = SEG[4]; if_b.seg_1 = SEG[3];
        @(negedge CLK);
        RST = 1'b0; if_a.SMP = 1'b0; if_b.SMP = 1'b0;
        chk("t6_rst_bcd",    {if_a.bcd_1, if_a.bcd_0}, 8'h00);
        chk("t6_rst_dv",     if_a.dv, 1'b0);
        chk("t6_rst_locked", if_a.locked, 1'b0);
        chk("t6_rst_err",    if_a.err, 1'b0);
        chk("t6_rst_errcnt", if_a.err_cnt, 8'd0);
        chk("t6_rst_stall",  if_a.stall, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
